ram32x4_arbiter: RTL and testbench

Controller that shares one single-port 32x4 RAM (registered address/data/wren, q valid one clock after the address edge) between two requesters, port 0 and port 1. After reset it first clears every location to INIT_VALUE, then arbitrates round-robin, issuing at most one RAM access per clock. Read data returns through a registered pipeline. The block sits between the requesting FSMs and the RAM macro; it is the only driver of the RAM's address, data and wren pins.

---
 rtl/ram32x4_arbiter.sv | 131 +++++++++++++
 tb/tb_ram32x4_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram32x4_arbiter.sv
`timescale 1ns/1ps
// ram32x4_arbiter: clears a shared single-port RAM after reset, then grants one
// access per clock to two requesters round-robin, returning reads 2 clocks after ack.
module ram32x4_arbiter #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 4,
  parameter int                DEPTH      = 2 ** ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_ptr;        // port granted most recently
  logic                r_init_done;
  logic                r_tag_vld;    // read issued last cycle, ram_q valid now
  logic                r_tag_port;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_gnt_vld;
  logic                w_gnt_port;
  logic                w_gnt_we;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_port = 1'b0;
    if (r_state == ST_RUN) begin
      if (req0 && req1) begin
        w_gnt_vld  = 1'b1;
        w_gnt_port = ~r_ptr;
      end else if (req0) begin
        w_gnt_vld  = 1'b1;
        w_gnt_port = 1'b0;
      end else if (req1) begin
        w_gnt_vld  = 1'b1;
        w_gnt_port = 1'b1;
      end
    end
  end

  assign w_gnt_we = w_gnt_port ? we1 : we0;
  assign ack0     = w_gnt_vld & ~w_gnt_port;
  assign ack1     = w_gnt_vld &  w_gnt_port;

  // The RAM registers these pins itself, so they are driven combinationally.
  always_comb begin
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    if (r_state == ST_INIT) begin
      ram_wren    = 1'b1;
      ram_address = r_clr_cnt;
      ram_data    = INIT_VALUE;
    end else if (w_gnt_vld) begin
      ram_wren    = w_gnt_we;
      ram_address = w_gnt_port ? addr1  : addr0;
      ram_data    = w_gnt_port ? wdata1 : wdata0;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_clr_cnt   <= '0;
      r_ptr       <= 1'b1;
      r_init_done <= 1'b0;
      r_tag_vld   <= 1'b0;
      r_tag_port  <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_tag_vld  <= w_gnt_vld & ~w_gnt_we;
      r_tag_port <= w_gnt_port;
      r_rvalid0  <= r_tag_vld & ~r_tag_port;
      r_rvalid1  <= r_tag_vld &  r_tag_port;
      if (r_tag_vld && !r_tag_port) r_rdata0 <= ram_q;
      if (r_tag_vld &&  r_tag_port) r_rdata1 <= ram_q;

      case (r_state)
        ST_INIT: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_gnt_vld) r_ptr <= w_gnt_port;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_ram32x4_arbiter.sv
`timescale 1ns/1ps
// tb_ram32x4_arbiter: directed vector table, reset corner sequences and a random
// two-port phase scored against a memory-array/queue model of the arbiter.
module tb_ram32x4_arbiter;
  localparam int AW = 5;
  localparam int DW = 4;
  localparam int N  = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, rvalid0, rvalid1, ram_wren, init_done;
  logic [DW-1:0] rdata0, rdata1, ram_data, ram_q;
  logic [AW-1:0] ram_address;

  always #5 clock = ~clock;

  ram32x4_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .init_done(init_done)
  );

  // External RAM macro: registered address/data/wren, q one clock later.
  logic [DW-1:0] ram_mem [N];
  bit ram_scramble = 1'b1;
  always @(posedge clock) begin
    if (ram_scramble) begin
      for (int i = 0; i < N; i++) ram_mem[i] <= DW'($urandom_range(1, 15));
    end else if (ram_wren) begin
      ram_mem[ram_address] <= ram_data;
    end
    ram_q <= ram_mem[ram_address];
  end

  typedef struct {
    string         name;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          ack0, ack1, wren, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
  } vec_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  logic [DW-1:0] m_mem [N];
  rd_t           m_q[$];
  int            last_winner;
  logic [DW-1:0] exp_rd0, exp_rd1;
  int            n_vec = 0;
  int            n_bad = 0;
  vec_t          tbl[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input string n, input int r0, input int w0, input int a0,
                              input int d0, input int r1, input int w1, input int a1,
                              input int d1, input int k0, input int k1, input int wr,
                              input int v0, input int v1, input int rd0, input int rd1);
    vec_t v;
    v.name = n;
    v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.r1 = 1'(r1); v.w1 = 1'(w1); v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.ack0 = 1'(k0); v.ack1 = 1'(k1); v.wren = 1'(wr);
    v.rv0 = 1'(v0); v.rv1 = 1'(v1); v.rd0 = DW'(rd0); v.rd1 = DW'(rd1);
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    #1;
    check({v.name, ".ack0"},    32'(ack0),    32'(v.ack0));
    check({v.name, ".ack1"},    32'(ack1),    32'(v.ack1));
    check({v.name, ".wren"},    32'(ram_wren), 32'(v.wren));
    check({v.name, ".rvalid0"}, 32'(rvalid0), 32'(v.rv0));
    check({v.name, ".rvalid1"}, 32'(rvalid1), 32'(v.rv1));
    check({v.name, ".rdata0"},  32'(rdata0),  32'(v.rd0));
    check({v.name, ".rdata1"},  32'(rdata1),  32'(v.rd1));
    if (v.ack0) begin last_winner = 0; if (v.w0) m_mem[v.a0] = v.d0; end
    if (v.ack1) begin last_winner = 1; if (v.w1) m_mem[v.a1] = v.d1; end
    exp_rd0 = v.rd0;
    exp_rd1 = v.rd1;
    tick();
  endtask

  // Checks n clear cycles starting at counter 0; requests present must be ignored.
  task automatic init_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      check($sformatf("clr%0d.wren", k),  32'(ram_wren),    32'(1));
      check($sformatf("clr%0d.addr", k),  32'(ram_address), 32'(k));
      check($sformatf("clr%0d.data", k),  32'(ram_data),    32'(0));
      check($sformatf("clr%0d.acks", k),  32'({ack0, ack1}), 32'(0));
      check($sformatf("clr%0d.rv", k),    32'({rvalid0, rvalid1}), 32'(0));
      check($sformatf("clr%0d.done", k),  32'(init_done),   32'(0));
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            act[2];
    logic          we_r[2];
    logic [AW-1:0] ad_r[2];
    logic [DW-1:0] wd_r[2];
    int            gp;
    logic          e_rv0, e_rv1;
    rd_t           r;

    // Reset with a request already pending.
    req0 = 1'b1; we0 = 1'b0; addr0 = '0;
    tick();
    #1;
    check("rst.init_done", 32'(init_done), 32'(0));
    check("rst.ack0",      32'(ack0),      32'(0));
    check("rst.rvalid",    32'({rvalid0, rvalid1}), 32'(0));
    check("rst.rdata",     32'({rdata0, rdata1}),   32'(0));
    tick();
    ram_scramble = 1'b0;
    tick();
    reset = 1'b0;
    init_cycles(N);

    // First RUN cycle: pending read of address 0 is granted, then read every word.
    for (int k = 0; k < N + 2; k++) begin
      req0 = (k < N); we0 = 1'b0; addr0 = AW'(k);
      #1;
      if (k == 0) check("run0.init_done", 32'(init_done), 32'(1));
      check($sformatf("rdall%0d.ack0", k),    32'(ack0),    32'(k < N));
      check($sformatf("rdall%0d.rvalid0", k), 32'(rvalid0), 32'(k >= 2));
      check($sformatf("rdall%0d.rdata0", k),  32'(rdata0),  32'(0));
      tick();
    end

    foreach (m_mem[i]) m_mem[i] = '0;
    exp_rd0 = '0; exp_rd1 = '0; last_winner = 0;

    //            name       r0 w0 a0 d0    r1 w1 a1 d1   k0 k1 wr v0 v1 rd0  rd1
    tbl[0]  = mk("wr_a5",     1, 1, 5, 'hA,  0, 0, 0, 0,   1, 0, 1, 0, 0, 0,   0);
    tbl[1]  = mk("rd_a5",     1, 0, 5, 0,    0, 0, 0, 0,   1, 0, 0, 0, 0, 0,   0);
    tbl[2]  = mk("idle_a",    0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0);
    tbl[3]  = mk("rv_a5",     0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 1, 0, 'hA, 0);
    tbl[4]  = mk("pre3",      0, 0, 0, 0,    1, 1, 3, 3,   0, 1, 1, 0, 0, 'hA, 0);
    tbl[5]  = mk("pre7",      0, 0, 0, 0,    1, 1, 7, 7,   0, 1, 1, 0, 0, 'hA, 0);
    tbl[6]  = mk("pre1",      0, 0, 0, 0,    1, 1, 1, 1,   0, 1, 1, 0, 0, 'hA, 0);
    tbl[7]  = mk("pre2",      0, 0, 0, 0,    1, 1, 2, 2,   0, 1, 1, 0, 0, 'hA, 0);
    tbl[8]  = mk("cont0",     1, 0, 3, 0,    1, 0, 7, 0,   1, 0, 0, 0, 0, 'hA, 0);
    tbl[9]  = mk("cont1",     1, 0, 3, 0,    1, 0, 7, 0,   0, 1, 0, 0, 0, 'hA, 0);
    tbl[10] = mk("cont2",     1, 0, 3, 0,    1, 0, 7, 0,   1, 0, 0, 1, 0, 3,   0);
    tbl[11] = mk("cont3",     1, 0, 3, 0,    1, 0, 7, 0,   0, 1, 0, 0, 1, 3,   7);
    tbl[12] = mk("cont_rv0",  0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 1, 0, 3,   7);
    tbl[13] = mk("cont_rv1",  0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 1, 3,   7);
    tbl[14] = mk("pipe1",     0, 0, 0, 0,    1, 0, 1, 0,   0, 1, 0, 0, 0, 3,   7);
    tbl[15] = mk("pipe2",     0, 0, 0, 0,    1, 0, 2, 0,   0, 1, 0, 0, 0, 3,   7);
    tbl[16] = mk("pipe3",     0, 0, 0, 0,    1, 0, 3, 0,   0, 1, 0, 0, 1, 3,   1);
    tbl[17] = mk("pipe_rv2",  0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 1, 3,   2);
    tbl[18] = mk("pipe_rv3",  0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 1, 3,   3);
    tbl[19] = mk("pipe_hold", 0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0, 3,   3);
    tbl[20] = mk("raw_tie",   1, 1, 9, 'hC,  1, 0, 9, 0,   1, 0, 1, 0, 0, 3,   3);
    tbl[21] = mk("raw_rd",    0, 0, 0, 0,    1, 0, 9, 0,   0, 1, 0, 0, 0, 3,   3);
    tbl[22] = mk("raw_idle",  0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0, 3,   3);
    tbl[23] = mk("raw_rv",    0, 0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 1, 3,   'hC);
    for (int i = 0; i < 24; i++) apply_vec(tbl[i]);

    // Random traffic: each port holds its request until acked, then may issue another.
    act[0] = 1'b0; act[1] = 1'b0;
    for (int c = 0; c < 410; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (c < 400 && !act[p] && $urandom_range(0, 9) < 6) begin
          act[p]  = 1'b1;
          we_r[p] = 1'($urandom_range(0, 1));
          ad_r[p] = AW'($urandom);
          wd_r[p] = DW'($urandom);
        end
      end
      req0 = act[0]; we0 = we_r[0]; addr0 = ad_r[0]; wdata0 = wd_r[0];
      req1 = act[1]; we1 = we_r[1]; addr1 = ad_r[1]; wdata1 = wd_r[1];
      #1;
      gp = -1;
      if (act[0] && act[1]) gp = 1 - last_winner;
      else if (act[0])      gp = 0;
      else if (act[1])      gp = 1;
      e_rv0 = 1'b0; e_rv1 = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == c) begin
        r = m_q.pop_front();
        if (r.port == 0) begin e_rv0 = 1'b1; exp_rd0 = r.data; end
        else             begin e_rv1 = 1'b1; exp_rd1 = r.data; end
      end
      check($sformatf("rnd%0d.ack0", c),    32'(ack0),    32'(gp == 0));
      check($sformatf("rnd%0d.ack1", c),    32'(ack1),    32'(gp == 1));
      check($sformatf("rnd%0d.rvalid0", c), 32'(rvalid0), 32'(e_rv0));
      check($sformatf("rnd%0d.rvalid1", c), 32'(rvalid1), 32'(e_rv1));
      check($sformatf("rnd%0d.rdata0", c),  32'(rdata0),  32'(exp_rd0));
      check($sformatf("rnd%0d.rdata1", c),  32'(rdata1),  32'(exp_rd1));
      if (gp >= 0) begin
        check($sformatf("rnd%0d.wren", c), 32'(ram_wren),    32'(we_r[gp]));
        check($sformatf("rnd%0d.addr", c), 32'(ram_address), 32'(ad_r[gp]));
        if (we_r[gp]) begin
          check($sformatf("rnd%0d.data", c), 32'(ram_data), 32'(wd_r[gp]));
          m_mem[ad_r[gp]] = wd_r[gp];
        end else begin
          m_q.push_back('{gp, m_mem[ad_r[gp]], c + 2});
        end
        last_winner = gp;
        act[gp] = 1'b0;
      end else begin
        check($sformatf("rnd%0d.wren_idle", c), 32'(ram_wren), 32'(0));
      end
      tick();
    end
    check("rnd.queue_drained", 32'(m_q.size()), 32'(0));

    // Idle bus drives zeros.
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("idle.pins", 32'({ram_wren, ram_address, ram_data}), 32'(0));
    tick();

    // Reset one cycle after a read ack discards the read.
    apply_vec(mk("b_wr4",  1, 1, 4, 'hF, 0, 0, 0, 0, 1, 0, 1, 0, 0, int'(exp_rd0), int'(exp_rd1)));
    apply_vec(mk("b_rd4",  1, 0, 4, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0, int'(exp_rd0), int'(exp_rd1)));
    apply_vec(mk("b_idle", 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, int'(exp_rd0), int'(exp_rd1)));
    apply_vec(mk("b_rv4",  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0, 'hF,           int'(exp_rd1)));
    apply_vec(mk("b_rd4x", 1, 0, 4, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0, 'hF,           int'(exp_rd1)));
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = '0;
    reset = 1'b1;
    #1;
    check("b_rst.rvalid",    32'({rvalid0, rvalid1}), 32'(0));
    check("b_rst.rdata0",    32'(rdata0),    32'(0));
    check("b_rst.rdata1",    32'(rdata1),    32'(0));
    check("b_rst.init_done", 32'(init_done), 32'(0));
    check("b_rst.ack1",      32'(ack1),      32'(0));
    tick();
    tick();
    reset = 1'b0;
    init_cycles(10);

    // Reset again at clear counter 10; the clear must restart from 0.
    #1;
    check("a_pre.addr", 32'(ram_address), 32'(10));
    reset = 1'b1;
    #1;
    check("a_rst.addr",      32'(ram_address), 32'(0));
    check("a_rst.init_done", 32'(init_done),   32'(0));
    tick();
    tick();
    reset = 1'b0;
    init_cycles(N);
    req1 = 1'b0;
    #1;
    check("a_done.init_done", 32'(init_done), 32'(1));
    apply_vec(mk("c_rd4",  1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply_vec(mk("c_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_vec(mk("c_rv4",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
